// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Condition evaluation widens to all codes when PIPE_CTRL_ALLCOND_EN is defined.
package pipe_ctrl_pkg;

  localparam int RD_W  = 5;
  localparam int AOP_W = 3;

  localparam logic [10:0] OP_ADDS  = 11'h558;
  localparam logic [10:0] OP_SUBS  = 11'h758;
  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [10:0] OP_BR    = 11'h6B0;
  localparam logic [9:0]  OP_ADDI  = 10'h244;
  localparam logic [7:0]  OP_BCOND = 8'h54;
  localparam logic [7:0]  OP_CBZ   = 8'hB4;
  localparam logic [5:0]  OP_B     = 6'h05;
  localparam logic [5:0]  OP_BL    = 6'h25;

  localparam logic [AOP_W-1:0] ALU_ADD   = 3'b010;
  localparam logic [AOP_W-1:0] ALU_SUB   = 3'b110;
  localparam logic [AOP_W-1:0] ALU_PASSB = 3'b111;

  localparam logic [RD_W-1:0] LINK_REG = 5'd30;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_HS, CC_LO, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  typedef enum logic [2:0] {
    BK_NONE, BK_UNCOND, BK_REG, BK_CBZ, BK_COND
  } br_kind_e;

  typedef struct packed {
    logic             reg2loc;
    logic             reads_rn;
    logic             reads_r2;
    logic [RD_W-1:0]  rn;
    logic [RD_W-1:0]  r2;
    logic [1:0]       alusrc;
    logic [AOP_W-1:0] aluop;
    logic             flags_we;
    logic             mem_write;
    logic             mem_read;
    logic             regwrite;
    logic [1:0]       memtoreg;
    logic [RD_W-1:0]  rd;
    br_kind_e         br_kind;
    logic             uncond_br;
    cond_e            cond;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // f is ordered {N, Z, C, V}.
  function automatic logic cond_holds(input cond_e cc, input logic [3:0] f);
`ifdef PIPE_CTRL_ALLCOND_EN
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_HS:   return c;
      CC_LO:   return !c;
      CC_MI:   return n;
      CC_PL:   return !n;
      CC_VS:   return v;
      CC_VC:   return !v;
      CC_HI:   return c && !z;
      CC_LS:   return !(c && !z);
      CC_GE:   return n == v;
      CC_LT:   return n != v;
      CC_GT:   return !z && (n == v);
      CC_LE:   return !(!z && (n == v));
      CC_AL:   return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (cc == CC_LT) && (f[3] ^ f[0]);
`endif
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Purely combinational ID-stage decoder; anything unrecognised or invalid is a bubble.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output ctrl_t       ctrl
);

  logic unused;
  assign unused = ^instr[15:10];

  always_comb begin
    ctrl = CTRL_BUBBLE;
    if (valid) begin
      if (instr[31:21] == OP_ADDS || instr[31:21] == OP_SUBS) begin
        ctrl.reg2loc  = 1'b1;
        ctrl.reads_rn = 1'b1;
        ctrl.reads_r2 = 1'b1;
        ctrl.rn       = instr[9:5];
        ctrl.r2       = instr[20:16];
        ctrl.aluop    = (instr[31:21] == OP_ADDS) ? ALU_ADD : ALU_SUB;
        ctrl.flags_we = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.rd       = instr[4:0];
      end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
        // Store data comes from the Rt field, so the second read uses reg2loc=0.
        ctrl.reads_rn  = 1'b1;
        ctrl.rn        = instr[9:5];
        ctrl.alusrc    = 2'b01;
        ctrl.aluop     = ALU_ADD;
        ctrl.mem_read  = (instr[31:21] == OP_LDUR);
        ctrl.mem_write = (instr[31:21] == OP_STUR);
        ctrl.regwrite  = (instr[31:21] == OP_LDUR);
        ctrl.memtoreg  = (instr[31:21] == OP_LDUR) ? 2'b01 : 2'b00;
        ctrl.rd        = (instr[31:21] == OP_LDUR) ? instr[4:0] : '0;
        ctrl.reads_r2  = (instr[31:21] == OP_STUR);
        ctrl.r2        = (instr[31:21] == OP_STUR) ? instr[4:0] : '0;
      end else if (instr[31:21] == OP_BR) begin
        ctrl.reads_rn = 1'b1;
        ctrl.rn       = instr[9:5];
        ctrl.br_kind  = BK_REG;
      end else if (instr[31:22] == OP_ADDI) begin
        ctrl.reads_rn = 1'b1;
        ctrl.rn       = instr[9:5];
        ctrl.alusrc   = 2'b10;
        ctrl.aluop    = ALU_ADD;
        ctrl.regwrite = 1'b1;
        ctrl.rd       = instr[4:0];
      end else if (instr[31:24] == OP_BCOND) begin
        ctrl.br_kind = BK_COND;
        ctrl.cond    = cond_e'(instr[3:0]);
      end else if (instr[31:24] == OP_CBZ) begin
        ctrl.reads_r2 = 1'b1;
        ctrl.r2       = instr[4:0];
        ctrl.aluop    = ALU_PASSB;
        ctrl.br_kind  = BK_CBZ;
      end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
        ctrl.br_kind   = BK_UNCOND;
        ctrl.uncond_br = 1'b1;
        if (instr[31:26] == OP_BL) begin
          ctrl.regwrite = 1'b1;
          ctrl.memtoreg = 2'b10;
          ctrl.rd       = LINK_REG;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode, ID/EX-EX/MEM-MEM/WB control registers, NZCV, load-use stall, ID branches.
// Condition-code coverage is widened by defining PIPE_CTRL_ALLCOND_EN.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3,
  parameter int ZR_IDX  = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr_id,
  input  logic               id_valid,
  input  logic               alu_n,
  input  logic               alu_z,
  input  logic               alu_v,
  input  logic               alu_c,
  input  logic               cbz_zero,
  output logic               reg2loc,
  output logic [1:0]         ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_flags_we,
  output logic               mem_write,
  output logic               mem_read,
  output logic               wb_regwrite,
  output logic [1:0]         wb_memtoreg,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [1:0]         br_taken,
  output logic               uncond_br,
  output logic               stall,
  output logic               flush
);

  localparam logic [RD_W-1:0] ZR = RD_W'(ZR_IDX);

  ctrl_t      id_ctrl, id_ex, ex_mem, mem_wb;
  logic [3:0] nzcv, flags_fwd;
  logic       after_rst, hazard, quiet;
  logic [1:0] br_raw;
  logic       unused;

  ctrl_decode u_decode (
    .instr (instr_id),
    .valid (id_valid),
    .ctrl  (id_ctrl)
  );

  assign flags_fwd = id_ex.flags_we ? {alu_n, alu_z, alu_c, alu_v} : nzcv;

  assign hazard = id_ex.mem_read && (id_ex.rd != ZR) &&
                  ((id_ctrl.reads_rn && (id_ctrl.rn == id_ex.rd)) ||
                   (id_ctrl.reads_r2 && (id_ctrl.r2 == id_ex.rd)));

  // Reset and the cycle right after it never stall or redirect.
  assign stall = hazard && !reset && !after_rst;
  assign quiet = stall || reset || after_rst;

  always_comb begin
    br_raw = 2'b00;
    case (id_ctrl.br_kind)
      BK_UNCOND: br_raw = 2'b01;
      BK_REG:    br_raw = 2'b10;
      BK_CBZ:    br_raw = cbz_zero ? 2'b01 : 2'b00;
      BK_COND:   br_raw = cond_holds(id_ctrl.cond, flags_fwd) ? 2'b01 : 2'b00;
      default:   br_raw = 2'b00;
    endcase
  end

  assign br_taken  = quiet ? 2'b00 : br_raw;
  assign flush     = (br_taken != 2'b00);
  assign reg2loc   = id_ctrl.reg2loc;
  assign uncond_br = id_ctrl.uncond_br;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex     <= CTRL_BUBBLE;
      ex_mem    <= CTRL_BUBBLE;
      mem_wb    <= CTRL_BUBBLE;
      nzcv      <= 4'b0000;
      after_rst <= 1'b1;
    end else begin
      id_ex     <= stall ? CTRL_BUBBLE : id_ctrl;
      ex_mem    <= id_ex;
      mem_wb    <= ex_mem;
      after_rst <= 1'b0;
      if (id_ex.flags_we) nzcv <= {alu_n, alu_z, alu_c, alu_v};
    end
  end

  assign ex_alusrc   = id_ex.alusrc;
  assign ex_aluop    = ALUOP_W'(id_ex.aluop);
  assign ex_flags_we = id_ex.flags_we;
  assign mem_write   = ex_mem.mem_write;
  assign mem_read    = ex_mem.mem_read;
  assign wb_regwrite = mem_wb.regwrite;
  assign wb_memtoreg = mem_wb.memtoreg;
  assign wb_rd       = REG_AW'(mem_wb.rd);

  assign unused = ^{id_ex, ex_mem, mem_wb};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; WB-stage results are tracked through an expected queue.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_id;
  logic        id_valid;
  logic        alu_n, alu_z, alu_v, alu_c;
  logic        cbz_zero;
  logic        reg2loc;
  logic [1:0]  ex_alusrc;
  logic [2:0]  ex_aluop;
  logic        ex_flags_we;
  logic        mem_write, mem_read;
  logic        wb_regwrite;
  logic [1:0]  wb_memtoreg;
  logic [4:0]  wb_rd;
  logic [1:0]  br_taken;
  logic        uncond_br, stall, flush;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .cbz_zero(cbz_zero),
    .reg2loc(reg2loc), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_flags_we(ex_flags_we),
    .mem_write(mem_write), .mem_read(mem_read), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .br_taken(br_taken), .uncond_br(uncond_br),
    .stall(stall), .flush(flush)
  );

  function automatic logic [31:0] enc_adds(input logic [4:0] rd, rn, rm);
    return {11'h558, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_subs(input logic [4:0] rd, rn, rm);
    return {11'h758, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_ldur(input logic [4:0] rt, rn);
    return {11'h7C2, 9'd8, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_stur(input logic [4:0] rt, rn);
    return {11'h7C0, 9'd8, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_bcond(input logic [3:0] cc);
    return {8'h54, 19'd16, 1'b0, cc};
  endfunction
  function automatic logic [31:0] enc_cbz(input logic [4:0] rt);
    return {8'hB4, 19'd12, rt};
  endfunction
  function automatic logic [31:0] enc_br(input logic [4:0] rn);
    return {11'h6B0, 5'h1F, 6'd0, rn, 5'd0};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] off);
    return {6'h05, off};
  endfunction
  function automatic logic [31:0] enc_bl(input logic [25:0] off);
    return {6'h25, off};
  endfunction
  function automatic logic [7:0] wb_ent(input logic rw, input logic [1:0] m2r, input logic [4:0] rd);
    return {rw, m2r, rd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    instr_id = ins;
    id_valid = v;
    #1;
  endtask

  // Pushes what enters ID/EX at this edge; WB shows the entry pushed two edges earlier.
  task automatic tick(input logic [7:0] e);
    logic [7:0] want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check("wb_stage", {wb_regwrite, wb_memtoreg, wb_rd}, want);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_ctl", {stall, flush, br_taken}, 0);
    @(posedge clk);
    #1;
    check("rst_nzcv", dut.nzcv, 0);
    check("rst_ex", {ex_alusrc, ex_aluop, ex_flags_we}, 0);
    check("rst_mem", {mem_write, mem_read}, 0);
    check("rst_wb", {wb_regwrite, wb_memtoreg, wb_rd}, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ctl", {stall, flush, br_taken}, 0);
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
  endtask

  initial begin
    reset = 1'b0; instr_id = '0; id_valid = 1'b0;
    alu_n = 1'b0; alu_z = 1'b0; alu_v = 1'b0; alu_c = 1'b0; cbz_zero = 1'b0;

    // Unconditional branch sits in ID through reset and the first cycle after it.
    drive(enc_b(26'd4), 1'b1);
    do_reset();
    tick(8'h00);

    // Undefined opcode and an invalid slot both decode as bubbles.
    drive(32'h0000_0000, 1'b1);
    check("zero_id", {reg2loc, uncond_br, br_taken, flush, stall}, 0);
    tick(8'h00);
    check("zero_ex", {ex_alusrc, ex_aluop, ex_flags_we}, 0);
    drive(enc_adds(5'd3, 5'd4, 5'd5), 1'b0);
    check("inv_id", {reg2loc, uncond_br, br_taken, flush, stall}, 0);
    tick(8'h00);
    check("inv_ex", {ex_alusrc, ex_aluop, ex_flags_we}, 0);

    // B.LT using flags forwarded from ADDS in EX.
    drive(enc_adds(5'd4, 5'd5, 5'd6), 1'b1);
    check("adds_reg2loc", reg2loc, 1);
    tick(wb_ent(1'b1, 2'b00, 5'd4));
    alu_n = 1'b1; alu_v = 1'b0;
    drive(enc_bcond(4'd11), 1'b1);
    check("blt_fwd_br", br_taken, 2'b01);
    check("blt_fwd_flush", flush, 1);
    check("blt_ex_flags_we", ex_flags_we, 1);
    tick(8'h00);
    check("nzcv_update", dut.nzcv, 4'b1000);
    alu_n = 1'b0;
    drive(enc_bcond(4'd11), 1'b1);
    check("blt_reg_br", br_taken, 2'b01);
    tick(8'h00);
    // Forwarded N=V overrides the stored N=1,V=0.
    drive(enc_adds(5'd7, 5'd8, 5'd9), 1'b1);
    tick(wb_ent(1'b1, 2'b00, 5'd7));
    alu_n = 1'b1; alu_v = 1'b1;
    drive(enc_bcond(4'd11), 1'b1);
    check("blt_fwd_not", {br_taken, flush}, 0);
    tick(8'h00);
    alu_n = 1'b0; alu_v = 1'b0;

    // Load-use on Rm.
    drive(enc_ldur(5'd1, 5'd9), 1'b1);
    check("lu_no_stall_ld", stall, 0);
    tick(wb_ent(1'b1, 2'b01, 5'd1));
    drive(enc_adds(5'd2, 5'd1, 5'd3), 1'b1);
    check("lu_stall", stall, 1);
    check("lu_stall_flush", {br_taken, flush}, 0);
    tick(8'h00);
    check("lu_ex_bubble", {ex_alusrc, ex_aluop, ex_flags_we}, 0);
    check("lu_mem_read", mem_read, 1);
    check("lu_stall_clear", stall, 0);
    tick(wb_ent(1'b1, 2'b00, 5'd2));
    drive(32'h0, 1'b0);
    tick(8'h00);
    tick(8'h00);
    check("lu_wb_rd", wb_rd, 5'd2);

    // Load-use on the STUR data register (reg2loc=0 path).
    drive(enc_ldur(5'd7, 5'd9), 1'b1);
    tick(wb_ent(1'b1, 2'b01, 5'd7));
    drive(enc_stur(5'd7, 5'd10), 1'b1);
    check("stur_reg2loc", reg2loc, 0);
    check("stur_stall", stall, 1);
    tick(8'h00);
    check("stur_stall_clear", stall, 0);
    tick(8'h00);
    drive(32'h0, 1'b0);
    tick(8'h00);
    check("stur_mem_write", mem_write, 1);

    // Zero register never hazards.
    drive(enc_ldur(5'd31, 5'd9), 1'b1);
    tick(wb_ent(1'b1, 2'b01, 5'd31));
    drive(enc_adds(5'd2, 5'd31, 5'd31), 1'b1);
    check("zr_no_stall", stall, 0);
    tick(wb_ent(1'b1, 2'b00, 5'd2));

    // CBZ and BR.
    cbz_zero = 1'b1;
    drive(enc_cbz(5'd5), 1'b1);
    check("cbz_taken", {br_taken, flush, reg2loc}, {2'b01, 1'b1, 1'b0});
    cbz_zero = 1'b0;
    #1;
    check("cbz_not_taken", {br_taken, flush}, 0);
    tick(8'h00);
    drive(enc_br(5'd12), 1'b1);
    check("br_reg", {br_taken, flush, reg2loc}, {2'b10, 1'b1, 1'b0});
    tick(8'h00);

    // BL links into X30 three cycles later.
    drive(enc_bl(26'd5), 1'b1);
    check("bl_id", {br_taken, flush, uncond_br}, {2'b01, 1'b1, 1'b1});
    tick(wb_ent(1'b1, 2'b10, 5'd30));
    drive(32'h0, 1'b0);
    tick(8'h00);
    tick(8'h00);
    check("bl_wb", {wb_regwrite, wb_memtoreg, wb_rd}, {1'b1, 2'b10, 5'd30});

    // SUBS producing Z=1, then B.EQ.
    drive(enc_subs(5'd5, 5'd6, 5'd7), 1'b1);
    tick(wb_ent(1'b1, 2'b00, 5'd5));
    alu_z = 1'b1;
    drive(enc_bcond(4'd0), 1'b1);
`ifdef PIPE_CTRL_ALLCOND_EN
    check("beq_taken", {br_taken, flush}, {2'b01, 1'b1});
`else
    check("beq_not_taken", {br_taken, flush}, 0);
`endif
    tick(8'h00);
    alu_z = 1'b0;

    // Reset arriving while a load-use stall is active.
    drive(enc_ldur(5'd1, 5'd9), 1'b1);
    tick(wb_ent(1'b1, 2'b01, 5'd1));
    drive(enc_adds(5'd2, 5'd1, 5'd3), 1'b1);
    check("mid_stall", stall, 1);
    do_reset();
    tick(wb_ent(1'b1, 2'b00, 5'd2));
    drive(32'h0, 1'b0);
    tick(8'h00);
    tick(8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
